buzz_drv: RTL and testbench

//   Piezo buzzer driver. It produces the complementary square-wave pair buzz/buzz_n.
//   On a start pulse it plays a burst of num_beeps tone beeps, with silent gaps between beeps.
//   It sits directly upstream of the buzz edge counter: buzz and buzz_n go to the pads and to that counter.

---
 rtl/buzz_drv.sv | 141 ++++++++++++++
 tb/tb_buzz_drv.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/buzz_drv.sv
// Piezo buzzer driver: complementary square-wave pair, played as a
// burst of beeps separated by silent gaps.
module buzz_drv #(
  parameter logic [13:0] HALF_PER    = 14'd12500,
  parameter logic [7:0]  ON_PERIODS  = 8'd200,
  parameter logic [7:0]  OFF_PERIODS = 8'd100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] num_beeps,
  input  logic       abort,
  output logic       buzz,
  output logic       buzz_n,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    BEEP,
    GAP
  } state_t;

  state_t      state;
  logic [13:0] half_cnt;
  logic [7:0]  per_cnt;
  logic [3:0]  beep_cnt;
  logic        ph;
  logic        half_end;
  logic        on_last;
  logic        off_last;

  assign half_end = (half_cnt == HALF_PER - 14'd1);
  assign on_last  = (per_cnt == ON_PERIODS - 8'd1);
  assign off_last = (per_cnt == OFF_PERIODS - 8'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      half_cnt <= '0;
      per_cnt  <= '0;
      beep_cnt <= '0;
      ph       <= 1'b0;
      buzz     <= 1'b0;
      buzz_n   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            if (num_beeps == 4'd0) begin
              done <= 1'b1;
            end else begin
              state    <= BEEP;
              busy     <= 1'b1;
              buzz     <= 1'b1;
              buzz_n   <= 1'b0;
              beep_cnt <= num_beeps - 4'd1;
              half_cnt <= '0;
              per_cnt  <= '0;
              ph       <= 1'b0;
            end
          end
        end
        BEEP: begin
          if (abort) begin
            state    <= IDLE;
            half_cnt <= '0;
            per_cnt  <= '0;
            beep_cnt <= '0;
            ph       <= 1'b0;
            buzz     <= 1'b0;
            buzz_n   <= 1'b0;
            busy     <= 1'b0;
          end else if (!half_end) begin
            half_cnt <= half_cnt + 14'd1;
          end else begin
            half_cnt <= '0;
            if (buzz) begin
              buzz   <= 1'b0;
              buzz_n <= 1'b1;
            end else if (!on_last) begin
              per_cnt <= per_cnt + 8'd1;
              buzz    <= 1'b1;
              buzz_n  <= 1'b0;
            end else begin
              // beep finished after its last low half: silence both phases
              buzz    <= 1'b0;
              buzz_n  <= 1'b0;
              per_cnt <= '0;
              if (beep_cnt == 4'd0) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state    <= GAP;
                beep_cnt <= beep_cnt - 4'd1;
                ph       <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          if (abort) begin
            state    <= IDLE;
            half_cnt <= '0;
            per_cnt  <= '0;
            beep_cnt <= '0;
            ph       <= 1'b0;
            buzz     <= 1'b0;
            buzz_n   <= 1'b0;
            busy     <= 1'b0;
          end else if (!half_end) begin
            half_cnt <= half_cnt + 14'd1;
          end else begin
            half_cnt <= '0;
            if (!ph) begin
              ph <= 1'b1;
            end else if (!off_last) begin
              ph      <= 1'b0;
              per_cnt <= per_cnt + 8'd1;
            end else begin
              state   <= BEEP;
              ph      <= 1'b0;
              per_cnt <= '0;
              buzz    <= 1'b1;
              buzz_n  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzz_drv.sv
// Scoreboard bench for buzz_drv with HALF_PER=4, ON_PERIODS=3,
// OFF_PERIODS=2: beep 24 cycles, gap 16 cycles.
module tb_buzz_drv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] num_beeps;
  logic       abort;
  logic       buzz;
  logic       buzz_n;
  logic       busy;
  logic       done;

  buzz_drv #(
    .HALF_PER   (14'd4),
    .ON_PERIODS (8'd3),
    .OFF_PERIODS(8'd2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_beeps(num_beeps),
    .abort    (abort),
    .buzz     (buzz),
    .buzz_n   (buzz_n),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   rb     = 0;
  int   rbn    = 0;
  logic pb     = 1'b0;
  logic pbn    = 1'b0;

  // expected {buzz,buzz_n,busy,done} t cycles after the accepting edge
  function automatic logic [3:0] burst_exp(int t, int n);
    int len;
    int m;
    if (n == 0) return (t == 0) ? 4'b0001 : 4'b0000;
    len = n * 24 + (n - 1) * 16;
    if (t < len) begin
      m = t % 40;
      if (m < 24) begin
        if ((m % 8) < 4) return 4'b1010;
        else return 4'b0110;
      end
      return 4'b0010;
    end
    if (t == len) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic step(input logic [3:0] v, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    e.v   = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d want %0d", tag, act, req);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    if (q.size() > 0) chk("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] act;
    act = {buzz, buzz_n, busy, done};
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (act === e.v) passed++;
      else $display("FAIL %s: got %b want %b", e.tag, act, e.v);
    end
    if (buzz && !pb) rb++;
    if (buzz_n && !pbn) rbn++;
    pb  = buzz;
    pbn = buzz_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    int bn0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    num_beeps = 4'd0;
    repeat (3) step(4'b0000, "reset");
    rst_n = 1'b1;
    repeat (5) step(4'b0000, "idle");
    drain();

    b0        = rb;
    bn0       = rbn;
    num_beeps = 4'd2;
    start     = 1'b1;
    for (int t = 0; t < 67; t++) begin
      step(burst_exp(t, 2), "burst2");
      if (t == 0) start = 1'b0;
    end
    drain();
    chk("buzz_rises", rb - b0, 6);
    chk("buzz_n_rises", rbn - bn0, 6);

    b0        = rb;
    num_beeps = 4'd0;
    start     = 1'b1;
    step(burst_exp(0, 0), "zero_beeps");
    start = 1'b0;
    for (int t = 1; t < 4; t++) step(burst_exp(t, 0), "zero_after");
    drain();
    chk("zero_rises", rb - b0, 0);

    num_beeps = 4'd2;
    start     = 1'b1;
    abort     = 1'b1;
    step(4'b0000, "abort_idle");
    start = 1'b0;
    abort = 1'b0;
    step(4'b0000, "abort_idle2");

    start = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step(burst_exp(t, 2), "pre_abort");
      if (t == 0) start = 1'b0;
    end
    abort = 1'b1;
    step(4'b0000, "abort");
    abort = 1'b0;
    step(4'b0000, "post_abort");
    start = 1'b1;
    for (int t = 0; t < 67; t++) begin
      step(burst_exp(t, 2), "after_abort");
      if (t == 0) start = 1'b0;
    end

    start = 1'b1;
    for (int t = 0; t < 65; t++) begin
      step(burst_exp(t, 2), "restart_ign");
      if (t == 0) start = 1'b0;
      if (t == 4) begin
        start     = 1'b1;
        num_beeps = 4'd7;
      end
      if (t == 5) start = 1'b0;
      if (t == 63) begin
        start     = 1'b1;
        num_beeps = 4'd1;
      end
    end
    for (int t = 0; t < 27; t++) begin
      step(burst_exp(t, 1), "after_done");
      if (t == 0) start = 1'b0;
    end

    num_beeps = 4'd2;
    start     = 1'b1;
    for (int t = 0; t < 30; t++) begin
      step(burst_exp(t, 2), "pre_rst");
      if (t == 0) start = 1'b0;
    end
    rst_n = 1'b0;
    step(4'b0000, "rst_mid");
    rst_n = 1'b1;
    repeat (4) step(4'b0000, "post_rst");
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
